button_array_controller: RTL and testbench



---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 176 +++++++++++++++++
 rtl/button_array_controller.sv | 74 +++++++
 tb/tb_button_array_controller.sv | 139 +++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and width helpers for the button array
package button_pkg;

    localparam int unsigned TIMER_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WAIT2 = 2'd2
    } btn_state_e;

    // Width able to hold max_ms ticks with headroom so saturation sits above every match value.
    function automatic int unsigned ms_width(input int unsigned max_ms);
        int unsigned w;
        w = $clog2(max_ms + 1) + 1;
        return (w > TIMER_W_MAX) ? TIMER_W_MAX : w;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce, event FSM and tick timers
module button_channel
    import button_pkg::*;
#(
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned DELAY_MS    = 500,
    parameter int unsigned REPEAT_MS   = 200,
    parameter int unsigned DOUBLE_MS   = 400,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned TW          = ms_width(1000)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic din_i,
    input  logic rep_en_i,
    output logic held_o,
    output logic press_o,
    output logic unpress_o,
    output logic autorep_o,
    output logic double_o,
    output logic long_press_o
);

    localparam int unsigned   DW       = ms_width(DEBOUNCE_MS);
    localparam logic          IDLE_LVL = 1'(ACTIVE_LOW);
    localparam logic [DW-1:0] DEB_LAST = DW'((DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0);
    localparam logic [TW-1:0] DELAY_T  = TW'(DELAY_MS);
    localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_MS);
    localparam logic [TW-1:0] DOUBLE_T = TW'(DOUBLE_MS);
    localparam logic [TW-1:0] LONG_T   = TW'(LONG_MS);
    localparam logic [TW-1:0] TMAX     = '1;

    logic          sync1_q, sync2_q;
    logic          pressed;
    logic          held_q, held_d, held;
    logic [DW-1:0] deb_q, deb_d;

    btn_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    logic [TW-1:0] rep_q, rep_d, rep_inc;
    logic          after_dbl_q, after_dbl_d;
    logic          press_q, press_d, unpress_q, unpress_d;
    logic          autorep_q, autorep_d, double_q, double_d, long_q, long_d;

    assign pressed = sync2_q ^ IDLE_LVL;
    assign held    = (DEBOUNCE_MS == 0) ? pressed : held_q;

    always_comb begin
        held_d = held_q;
        deb_d  = deb_q;
        if (DEBOUNCE_MS == 0) begin
            held_d = pressed;
            deb_d  = '0;
        end else if (pressed == held_q) begin
            deb_d = '0;
        end else if (tick_i) begin
            if (deb_q == DEB_LAST) begin
                held_d = ~held_q;
                deb_d  = '0;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    assign tmr_inc = (tmr_q == TMAX) ? tmr_q : tmr_q + 1'b1;
    assign rep_inc = rep_q + 1'b1;

    // One timer serves both states: hold duration in HOLD, window age in WAIT2.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        rep_d       = rep_q;
        after_dbl_d = after_dbl_q;
        press_d     = 1'b0;
        unpress_d   = 1'b0;
        autorep_d   = 1'b0;
        double_d    = 1'b0;
        long_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (held) begin
                    state_d = ST_HOLD;
                    press_d = 1'b1;
                    tmr_d   = '0;
                    rep_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!held) begin
                    state_d   = ST_WAIT2;
                    unpress_d = 1'b1;
                    tmr_d     = '0;
                end else if (tick_i) begin
                    tmr_d = tmr_inc;
                    if (tmr_inc == DELAY_T) begin
                        autorep_d = rep_en_i;
                        rep_d     = '0;
                    end else if (tmr_inc > DELAY_T) begin
                        if (rep_inc == REPEAT_T) begin
                            autorep_d = rep_en_i;
                            rep_d     = '0;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end
                    if (LONG_MS != 0 && tmr_inc == LONG_T) begin
                        long_d = 1'b1;
                    end
                end
            end
            ST_WAIT2: begin
                if (held) begin
                    state_d = ST_HOLD;
                    press_d = 1'b1;
                    tmr_d   = '0;
                    rep_d   = '0;
                    if (tmr_q >= DOUBLE_T) begin
                        after_dbl_d = 1'b0;
                    end else if (!after_dbl_q) begin
                        double_d    = 1'b1;
                        after_dbl_d = 1'b1;
                    end
                end else if (tmr_q >= DOUBLE_T) begin
                    state_d     = ST_IDLE;
                    after_dbl_d = 1'b0;
                end else if (tick_i) begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q     <= IDLE_LVL;
            sync2_q     <= IDLE_LVL;
            held_q      <= 1'b0;
            deb_q       <= '0;
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            rep_q       <= '0;
            after_dbl_q <= 1'b0;
            press_q     <= 1'b0;
            unpress_q   <= 1'b0;
            autorep_q   <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= din_i;
            sync2_q     <= sync1_q;
            held_q      <= held_d;
            deb_q       <= deb_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rep_q       <= rep_d;
            after_dbl_q <= after_dbl_d;
            press_q     <= press_d;
            unpress_q   <= unpress_d;
            autorep_q   <= autorep_d;
            double_q    <= double_d;
            long_q      <= long_d;
        end
    end

    assign held_o       = held;
    assign press_o      = press_q;
    assign unpress_o    = unpress_q;
    assign autorep_o    = autorep_q;
    assign double_o     = double_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/button_array_controller.sv
// rtl/button_array_controller.sv - shared millisecond prescaler driving N_CH button channels
module button_array_controller
    import button_pkg::*;
#(
    parameter int unsigned     CLK_HZ      = 50000000,
    parameter int unsigned     N_CH        = 4,
    parameter bit              ACTIVE_LOW  = 1'b1,
    parameter int unsigned     DEBOUNCE_MS = 10,
    parameter int unsigned     DELAY_MS    = 500,
    parameter int unsigned     REPEAT_MS   = 200,
    parameter int unsigned     DOUBLE_MS   = 400,
    parameter int unsigned     LONG_MS     = 1000,
    parameter logic [N_CH-1:0] REPEAT_EN   = {N_CH{1'b1}}
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] din_i,
    output logic [N_CH-1:0] held_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] unpress_o,
    output logic [N_CH-1:0] autorep_o,
    output logic [N_CH-1:0] double_o,
    output logic [N_CH-1:0] long_press_o
);

    localparam int unsigned   DIV      = CLK_HZ / 1000;
    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    localparam int unsigned MAX_A = (DELAY_MS > REPEAT_MS) ? DELAY_MS : REPEAT_MS;
    localparam int unsigned MAX_B = (DOUBLE_MS > LONG_MS) ? DOUBLE_MS : LONG_MS;
    localparam int unsigned TW    = ms_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == DIV_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .DELAY_MS    (DELAY_MS),
            .REPEAT_MS   (REPEAT_MS),
            .DOUBLE_MS   (DOUBLE_MS),
            .LONG_MS     (LONG_MS),
            .TW          (TW)
        ) u_ch (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .tick_i       (tick),
            .din_i        (din_i[g]),
            .rep_en_i     (REPEAT_EN[g]),
            .held_o       (held_o[g]),
            .press_o      (press_o[g]),
            .unpress_o    (unpress_o[g]),
            .autorep_o    (autorep_o[g]),
            .double_o     (double_o[g]),
            .long_press_o (long_press_o[g])
        );
    end

endmodule

// File: tb/tb_button_array_controller.sv
// tb/tb_button_array_controller.sv - directed bench with cycle-stamped event lists
module tb_button_array_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din = 2'b11;
    logic [1:0] held, press, unpress, autorep, dbl, lng;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q_press0[$], q_unp0[$], q_rep0[$], q_long0[$], q_dbl0[$];
    int q_press1[$], q_unp1[$], q_rep1[$], q_long1[$], q_dbl1[$];
    int e_q[$];

    always #5 clk = ~clk;

    button_array_controller #(
        .CLK_HZ      (10000),
        .N_CH        (2),
        .ACTIVE_LOW  (1'b1),
        .DEBOUNCE_MS (2),
        .DELAY_MS    (5),
        .REPEAT_MS   (2),
        .DOUBLE_MS   (4),
        .LONG_MS     (8),
        .REPEAT_EN   (2'b01)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .din_i        (din),
        .held_o       (held),
        .press_o      (press),
        .unpress_o    (unpress),
        .autorep_o    (autorep),
        .double_o     (dbl),
        .long_press_o (lng)
    );

    // cyc equals the number of rising edges since reset released; ticks land on multiples of 10.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (press[0])   q_press0.push_back(cyc);
        if (unpress[0]) q_unp0.push_back(cyc);
        if (autorep[0]) q_rep0.push_back(cyc);
        if (lng[0])     q_long0.push_back(cyc);
        if (dbl[0])     q_dbl0.push_back(cyc);
        if (press[1])   q_press1.push_back(cyc);
        if (unpress[1]) q_unp1.push_back(cyc);
        if (autorep[1]) q_rep1.push_back(cyc);
        if (lng[1])     q_long1.push_back(cyc);
        if (dbl[1])     q_dbl1.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check($sformatf("%s.count", tag), got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("reset_outputs", int'({held, press, unpress, autorep, dbl, lng}), 0);
        rst = 1'b0;

        // glitch on ch0: 15 cycles low, spans only one tick
        at(8);   din[0] = 1'b0;
        at(23);  din[0] = 1'b1;
        at(30);  check("glitch_held", int'(held[0]), 0);

        // 12 ms hold, double click, triple, late re-press
        at(108); din[0] = 1'b0;
        at(168); check("hold_held", int'(held[0]), 1);
        at(228); din[0] = 1'b1;
        at(248); din[0] = 1'b0;
        at(258); check("gap_held", int'(held[0]), 0);
        at(278); din[0] = 1'b1;
        at(298); din[0] = 1'b0;
        at(328); din[0] = 1'b1;
        at(388); din[0] = 1'b0;
        at(418); din[0] = 1'b1;

        // both channels pressed together
        at(508); din = 2'b00;
        at(568); din = 2'b11;

        // reset asserted 6 ms into a hold, button released while in reset
        at(708); din[0] = 1'b0;
        at(791);
        check("pre_reset_held", int'(held[0]), 1);
        rst = 1'b1;
        #1;
        check("reset_async_outputs", int'({held, press, unpress, autorep, dbl, lng}), 0);
        repeat (3) @(negedge clk);
        din = 2'b11;
        repeat (3) @(negedge clk);
        check("in_reset_outputs", int'({held, press, unpress, autorep, dbl, lng}), 0);
        rst = 1'b0;
        at(150);
        check("post_reset_held", int'(held[0]), 0);

        // fresh press after reset must start from IDLE (no double)
        at(158); din[0] = 1'b0;
        at(188); din[0] = 1'b1;
        at(300);

        e_q = '{131, 271, 321, 411, 531, 731, 181}; check_seq("press0",   q_press0, e_q);
        e_q = '{251, 301, 351, 441, 591, 211};      check_seq("unpress0", q_unp0,   e_q);
        e_q = '{180, 200, 220, 240, 580, 780};      check_seq("autorep0", q_rep0,   e_q);
        e_q = '{210};                               check_seq("long0",    q_long0,  e_q);
        e_q = '{271};                               check_seq("double0",  q_dbl0,   e_q);
        e_q = '{531};                               check_seq("press1",   q_press1, e_q);
        e_q = '{591};                               check_seq("unpress1", q_unp1,   e_q);
        e_q = {};                                   check_seq("autorep1", q_rep1,   e_q);
        check_seq("long1",   q_long1, e_q);
        check_seq("double1", q_dbl1,  e_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
